// File: rtl/axi_w_burst_master_if.sv
// AXI3 write-path channel bundle (AW, W, B) between the burst write master and the interconnect.
interface axi_w_burst_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 6,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) ();
    // Write address channel
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [3:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic [ID_WIDTH-1:0]   AWID;
    logic                  AWVALID;
    logic                  AWREADY;
    // Write data channel
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic [ID_WIDTH-1:0]   WID;
    logic                  WLAST;
    logic                  WVALID;
    logic                  WREADY;
    // Write response channel
    logic [1:0]            BRESP;
    logic [ID_WIDTH-1:0]   BID;
    logic                  BVALID;
    logic                  BREADY;

    // Handshake rule on every channel: a transfer happens on a rising ACLK edge where
    // VALID and READY are both high; the source holds VALID and its payload stable
    // until that edge, and VALID never waits on READY.
    modport master (
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WID, WLAST, WVALID,
        input  WREADY,
        input  BRESP, BID, BVALID,
        output BREADY
    );

    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WID, WLAST, WVALID,
        output WREADY,
        output BRESP, BID, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/axi_w_burst_master.sv
// AXI3 burst write master: one outstanding transaction, 1-16 beats, FIXED/INCR/WRAP,
// local legality check, independent AW and W progress, B response with ID-match check.
module axi_w_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 6,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    axi_w_burst_master_if.master  axi,
    // Request port (valid/ready)
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [3:0]            req_len,
    input  logic [2:0]            req_size,
    input  logic [1:0]            req_burst,
    input  logic [ID_WIDTH-1:0]   req_id,
    // Beat data port (valid/ready)
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [DATA_WIDTH-1:0] wd_data,
    input  logic [STRB_WIDTH-1:0] wd_strb,
    // Completion port (valid/ready)
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [1:0]            resp_code,
    output logic [ID_WIDTH-1:0]   resp_id,
    output logic                  resp_err,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, XFER, WAIT_B, RESP} state_t;

    localparam logic [2:0] SIZE_MAX   = 3'($clog2(STRB_WIDTH));
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [1:0] BURST_RSVD = 2'b11;

    state_t      r_state;
    logic [4:0]  r_ld_cnt;   // beats taken from wd so far; reaches 16 on a full-length burst
    logic        r_aw_done;
    logic        r_w_done;

    logic [12:0] w_bytes;
    logic [12:0] w_end;
    logic        w_wrap_len_ok;
    logic        w_illegal;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_wlast_hs;
    logic        w_wd_hs;
    logic        w_aw_ok;
    logic        w_w_ok;

    // Legality of the request currently offered on the request port
    assign w_bytes       = ({9'd0, req_len} + 13'd1) << req_size;
    assign w_end         = {1'b0, req_addr[11:0]} + w_bytes;
    assign w_wrap_len_ok = (req_len == 4'd1) || (req_len == 4'd3) ||
                           (req_len == 4'd7) || (req_len == 4'd15);
    assign w_illegal     = (req_burst == BURST_RSVD) ||
                           (req_size > SIZE_MAX) ||
                           ((req_burst == BURST_WRAP) && !w_wrap_len_ok) ||
                           ((req_burst == BURST_INCR) && (w_end > 13'd4096));

    // Channel handshakes seen this cycle
    assign w_aw_hs    = axi.AWVALID && axi.AWREADY;
    assign w_w_hs     = axi.WVALID && axi.WREADY;
    assign w_wlast_hs = w_w_hs && axi.WLAST;
    assign w_wd_hs    = wd_valid && wd_ready;
    assign w_aw_ok    = r_aw_done || w_aw_hs;
    assign w_w_ok     = r_w_done || w_wlast_hs;

    // A beat is taken only while beats remain and the W register is free or draining this cycle
    assign wd_ready   = (r_state == XFER) && (r_ld_cnt <= {1'b0, axi.AWLEN}) &&
                        (!axi.WVALID || axi.WREADY);
    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign resp_valid = (r_state == RESP);
    assign axi.BREADY = (r_state == WAIT_B);

    // Transaction FSM with the AW/W payload and completion registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= IDLE;
            r_ld_cnt    <= 5'd0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            axi.AWADDR  <= '0;
            axi.AWLEN   <= 4'd0;
            axi.AWSIZE  <= 3'd0;
            axi.AWBURST <= 2'd0;
            axi.AWID    <= '0;
            axi.AWVALID <= 1'b0;
            axi.WDATA   <= '0;
            axi.WSTRB   <= '0;
            axi.WID     <= '0;
            axi.WLAST   <= 1'b0;
            axi.WVALID  <= 1'b0;
            resp_code   <= 2'b00;
            resp_id     <= '0;
            resp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (w_illegal) begin
                            // Rejected locally: nothing goes out on AXI
                            resp_code <= 2'b10;
                            resp_err  <= 1'b1;
                            resp_id   <= req_id;
                            r_state   <= RESP;
                        end else begin
                            // AW payload doubles as the latched request for the whole transaction
                            axi.AWADDR  <= req_addr;
                            axi.AWLEN   <= req_len;
                            axi.AWSIZE  <= req_size;
                            axi.AWBURST <= req_burst;
                            axi.AWID    <= req_id;
                            axi.AWVALID <= 1'b1;
                            r_aw_done   <= 1'b0;
                            r_w_done    <= 1'b0;
                            r_ld_cnt    <= 5'd0;
                            r_state     <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (w_aw_hs) begin
                        axi.AWVALID <= 1'b0;
                        r_aw_done   <= 1'b1;
                    end
                    // W runs independently of AW; data may finish before the address
                    if (w_wd_hs) begin
                        axi.WDATA  <= wd_data;
                        axi.WSTRB  <= wd_strb;
                        axi.WID    <= axi.AWID;
                        axi.WVALID <= 1'b1;
                        axi.WLAST  <= (r_ld_cnt[3:0] == axi.AWLEN);
                        r_ld_cnt   <= r_ld_cnt + 5'd1;
                    end else if (axi.WREADY) begin
                        axi.WVALID <= 1'b0;
                        axi.WLAST  <= 1'b0;
                    end
                    if (w_wlast_hs) begin
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (axi.BVALID) begin
                        resp_code <= axi.BRESP;
                        resp_id   <= axi.BID;
                        resp_err  <= (axi.BID != axi.AWID);
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_w_burst_master.sv
// Directed bench for axi_w_burst_master: requester driver, AXI slave model, beat scoreboard.
module tb_axi_w_burst_master;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 6;
    localparam int SW = 4;
    localparam int BW = 1 + SW + DW;

    // ---------------- clock / reset ----------------
    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    logic          req_valid, req_ready;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_len;
    logic [2:0]    req_size;
    logic [1:0]    req_burst;
    logic [IW-1:0] req_id;
    logic          wd_valid, wd_ready;
    logic [DW-1:0] wd_data;
    logic [SW-1:0] wd_strb;
    logic          resp_valid, resp_ready;
    logic [1:0]    resp_code;
    logic [IW-1:0] resp_id;
    logic          resp_err;
    logic          busy;

    axi_w_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .STRB_WIDTH(SW)) axi ();

    axi_w_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .STRB_WIDTH(SW)) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .axi        (axi.master),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_size   (req_size),
        .req_burst  (req_burst),
        .req_id     (req_id),
        .wd_valid   (wd_valid),
        .wd_ready   (wd_ready),
        .wd_data    (wd_data),
        .wd_strb    (wd_strb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_code  (resp_code),
        .resp_id    (resp_id),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- slave model ----------------
    int            aw_mode = 0;     // 0: AWREADY high; 1: low until 8 cycles after WLAST
    int            w_mode  = 0;     // 0: WREADY high;  1: WREADY toggles every cycle
    logic [1:0]    b_resp  = 2'b00;
    bit            bid_ovr = 1'b0;
    logic [IW-1:0] bid_val = '0;
    int            clr_gen = 0;

    int            clr_seen = 0;
    bit            aw_seen, wl_seen, b_done, prev_stall;
    int            aw_cyc, wl_cyc, first_w, bready_first, aw_valid_cnt, stall_err, stall_cnt;
    logic [BW-1:0] prev_w;
    logic [IW-1:0] aw_id_cap;
    logic [AW-1:0] aw_addr_cap;
    logic [3:0]    aw_len_cap;
    logic [1:0]    aw_burst_cap;
    logic [BW-1:0] got_q[$];
    logic [BW-1:0] exp_q[$];

    always @(negedge ACLK) begin
        if (clr_seen != clr_gen) begin
            clr_seen = clr_gen;
            aw_seen = 0; wl_seen = 0; b_done = 0; prev_stall = 0;
            aw_cyc = 0; wl_cyc = 0; first_w = -1; bready_first = -1;
            aw_valid_cnt = 0; stall_err = 0; stall_cnt = 0;
            got_q.delete();
            axi.BVALID = 1'b0;
        end
        axi.AWREADY = (aw_mode == 0) ? 1'b1 : (wl_seen && (cyc >= wl_cyc + 9));
        axi.WREADY  = (w_mode == 0) ? 1'b1 : cyc[0];
        if (axi.BVALID && b_done) begin
            axi.BVALID = 1'b0;
        end else if (!axi.BVALID && !b_done && aw_seen && wl_seen &&
                     (cyc >= ((aw_cyc > wl_cyc) ? aw_cyc : wl_cyc) + 2)) begin
            axi.BVALID = 1'b1;
            axi.BRESP  = b_resp;
            axi.BID    = bid_ovr ? bid_val : aw_id_cap;
        end
        #1;
        if (axi.AWVALID) aw_valid_cnt++;
        if (axi.AWVALID && axi.AWREADY && !aw_seen) begin
            aw_seen = 1; aw_cyc = cyc;
            aw_id_cap = axi.AWID; aw_addr_cap = axi.AWADDR;
            aw_len_cap = axi.AWLEN; aw_burst_cap = axi.AWBURST;
        end
        if (axi.WVALID && !axi.WREADY) begin
            stall_cnt++;
            if (wd_ready) stall_err++;
            if (prev_stall && ({axi.WLAST, axi.WSTRB, axi.WDATA} != prev_w)) stall_err++;
            prev_stall = 1;
            prev_w = {axi.WLAST, axi.WSTRB, axi.WDATA};
        end else begin
            prev_stall = 0;
        end
        if (axi.WVALID && axi.WREADY) begin
            got_q.push_back({axi.WLAST, axi.WSTRB, axi.WDATA});
            if (first_w < 0) first_w = cyc;
            if (axi.WLAST) begin wl_seen = 1; wl_cyc = cyc; end
        end
        if (axi.BREADY && bready_first < 0) bready_first = cyc;
        if (axi.BVALID && axi.BREADY) b_done = 1;
    end

    // ---------------- requester driver ----------------
    int            acc_cyc, resp_cyc;
    bit            resp_seen;
    logic [1:0]    r_code;
    logic          r_err;
    logic [IW-1:0] r_id;

    task automatic do_write(input logic [AW-1:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [IW-1:0] id, input int n_beats,
                            input logic [DW-1:0] base);
        int to;
        clr_gen++;
        for (int i = 0; i < n_beats; i++)
            exp_q.push_back({(i == n_beats - 1), 4'hF ^ 4'(i), base + 32'(i)});
        @(negedge ACLK);
        req_valid = 1; req_addr = addr; req_len = len; req_size = size; req_burst = burst; req_id = id;
        #1; to = 0;
        while (!req_ready && to < 50) begin @(negedge ACLK); #1; to++; end
        acc_cyc = cyc;
        @(negedge ACLK);
        req_valid = 0;
        for (int i = 0; i < n_beats; i++) begin
            if (i > 0) @(negedge ACLK);
            wd_valid = 1; wd_data = base + 32'(i); wd_strb = 4'hF ^ 4'(i);
            #1; to = 0;
            while (!wd_ready && to < 100) begin @(negedge ACLK); #1; to++; end
            if (to >= 100) chk("wd_ready_timeout", 0, 1);
        end
        if (n_beats > 0) begin @(negedge ACLK); wd_valid = 0; end
        to = 0; resp_seen = 0;
        while (to < 300) begin
            #1;
            if (resp_valid) begin resp_seen = 1; break; end
            @(negedge ACLK);
            to++;
        end
        chk("resp_seen", resp_seen, 1);
        resp_cyc = cyc; r_code = resp_code; r_err = resp_err; r_id = resp_id;
        @(negedge ACLK);
    endtask

    task automatic check_beats(input string tag);
        chk({tag, "_nbeats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
        exp_q.delete();
    endtask

    // Illegal request table: 16 B across 4 KB, WRAP len 2, size above bus width, reserved burst
    logic [AW-1:0] il_addr  [4] = '{32'hFF8, 32'h200, 32'h0, 32'h10};
    logic [3:0]    il_len   [4] = '{4'd3, 4'd2, 4'd0, 4'd1};
    logic [2:0]    il_size  [4] = '{3'd2, 3'd2, 3'd3, 3'd2};
    logic [1:0]    il_burst [4] = '{2'b01, 2'b10, 2'b01, 2'b11};

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        req_valid = 0; req_addr = '0; req_len = 0; req_size = 0; req_burst = 0; req_id = '0;
        wd_valid = 0; wd_data = '0; wd_strb = '0; resp_ready = 1;

        // Reset state
        #3;
        chk("rst_awvalid", axi.AWVALID, 0);
        chk("rst_wvalid", axi.WVALID, 0);
        chk("rst_bready", axi.BREADY, 0);
        chk("rst_resp", {resp_valid, resp_code, resp_id, resp_err}, 0);
        chk("rst_busy_wdready", {busy, wd_ready}, 0);
        @(negedge ACLK); @(negedge ACLK);
        ARESETn = 1;
        #1;
        chk("rst_req_ready", req_ready, 1);

        // Single beat INCR
        do_write(32'h100, 4'd0, 3'd2, 2'b01, 6'd3, 1, 32'hDEADBEEF);
        check_beats("t1");
        chk("t1_latency", resp_cyc - acc_cyc, 5);
        chk("t1_code_err", {r_code, r_err}, {2'b00, 1'b0});
        chk("t1_awaddr", aw_addr_cap, 32'h100);
        chk("t1_bready_start", bready_first, wl_cyc + 1);
        chk("t1_idle_after", busy, 0);

        // 4-beat INCR with WREADY toggling
        w_mode = 1;
        do_write(32'h1000, 4'd3, 3'd2, 2'b01, 6'd1, 4, 32'h11110000);
        check_beats("t2");
        chk("t2_stall_err", stall_err, 0);
        chk("t2_stalls_seen", stall_cnt > 0, 1);
        chk("t2_awlen", aw_len_cap, 3);
        chk("t2_code", r_code, 0);
        w_mode = 0;

        // AW held off until 8 cycles after W completes
        aw_mode = 1;
        do_write(32'h300, 4'd1, 3'd2, 2'b01, 6'd2, 2, 32'h22220000);
        check_beats("t3");
        chk("t3_w_full_rate", wl_cyc - first_w, 1);
        chk("t3_aw_after_w", aw_cyc, wl_cyc + 9);
        chk("t3_waitb_after_aw", bready_first, aw_cyc + 1);
        chk("t3_code_err", {r_code, r_err}, 0);
        aw_mode = 0;

        // Illegal requests
        for (int k = 0; k < 4; k++) begin
            do_write(il_addr[k], il_len[k], il_size[k], il_burst[k], 6'(10 + k), 0, 32'h0);
            check_beats($sformatf("il%0d", k));
            chk($sformatf("il%0d_no_aw", k), aw_valid_cnt, 0);
            chk($sformatf("il%0d_latency", k), resp_cyc - acc_cyc, 1);
            chk($sformatf("il%0d_code_err", k), {r_code, r_err}, {2'b10, 1'b1});
            chk($sformatf("il%0d_id", k), r_id, 10 + k);
        end

        // INCR ending exactly on the 4 KB boundary is legal; BRESP passes through
        b_resp = 2'b01;
        do_write(32'hFF0, 4'd3, 3'd2, 2'b01, 6'd9, 4, 32'h33330000);
        check_beats("t4");
        chk("t4_code_err_id", {r_code, r_err, r_id}, {2'b01, 1'b0, 6'd9});
        b_resp = 2'b00;

        // WRAP 4 beats, BID mismatch
        bid_ovr = 1; bid_val = 6'd5;
        do_write(32'h40, 4'd3, 3'd2, 2'b10, 6'd3, 4, 32'h44440000);
        check_beats("t5");
        chk("t5_awid", aw_id_cap, 3);
        chk("t5_awburst", aw_burst_cap, 2'b10);
        chk("t5_full_rate", wl_cyc - first_w, 3);
        chk("t5_code_err_id", {r_code, r_err, r_id}, {2'b00, 1'b1, 6'd5});
        bid_ovr = 0;

        // FIXED 16 beats near 4 KB (no boundary rule for FIXED)
        do_write(32'hFFC, 4'd15, 3'd2, 2'b00, 6'd12, 16, 32'h55550000);
        check_beats("t6");
        chk("t6_code_err", {r_code, r_err}, 0);

        // Asynchronous reset after 2 of 8 beats
        clr_gen++;
        @(negedge ACLK);
        req_valid = 1; req_addr = 32'h2000; req_len = 4'd7; req_size = 3'd2; req_burst = 2'b01; req_id = 6'd7;
        @(negedge ACLK);
        req_valid = 0; wd_valid = 1; wd_data = 32'hA0; wd_strb = 4'hF;
        @(negedge ACLK);
        wd_data = 32'hA1;
        @(negedge ACLK);
        wd_valid = 0;
        #1;
        chk("t7_pre_rst_w", {axi.WVALID, axi.WDATA}, {1'b1, 32'hA1});
        chk("t7_pre_rst_busy", busy, 1);
        #1;
        ARESETn = 0;
        #1;
        chk("t7_rst_w", {axi.WVALID, axi.WLAST, axi.WDATA, axi.WID}, 0);
        chk("t7_rst_aw", {axi.AWVALID, axi.AWADDR, axi.AWLEN}, 0);
        chk("t7_rst_ctl", {busy, wd_ready, axi.BREADY, resp_valid}, 0);
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETn = 1;
        #1;
        chk("t7_req_ready", req_ready, 1);
        do_write(32'h3000, 4'd0, 3'd2, 2'b01, 6'd4, 1, 32'h55AA0001);
        check_beats("t7");
        chk("t7_latency", resp_cyc - acc_cyc, 5);
        chk("t7_code_err_id", {r_code, r_err, r_id}, {2'b00, 1'b0, 6'd4});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
